// File: rtl/stopwatch_counter.sv
// BCD mm:ss.cc stopwatch clocked at 1 MHz, advanced by synchronised rising edges of clk_100.
// Optional lap-freeze display is enabled by defining SW_LAP_EN.
module stopwatch_counter #(
    parameter int unsigned MINUTES_MAX = 59,
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic        clk_in,
    input  logic        res,
    input  logic        clk_100,
    input  logic        btn_start_stop,
    input  logic        btn_clear,
    input  logic        btn_lap,
    output logic [23:0] digits,
    output logic        running,
    output logic        overflow
);

    localparam logic [3:0] MinTMax = 4'(MINUTES_MAX / 10);
    localparam logic [3:0] MinUMax = 4'(MINUTES_MAX % 10);

`ifdef SW_LAP_EN
    typedef enum logic [1:0] {StIdle, StRun, StStop, StLap} state_e;
`else
    typedef enum logic [1:0] {StIdle, StRun, StStop} state_e;
    logic unused_btn_lap;
    assign unused_btn_lap = btn_lap;
`endif

    state_e                   state_q, state_d;
    logic [SYNC_STAGES-1:0]   sync_q;
    logic                     prev_q;
    logic [5:0][3:0]          cnt_q, cnt_d;
    logic [23:0]              digits_q, digits_d;
    logic                     running_q, running_d;
    logic                     overflow_q;
    logic                     tick, counting, clear_zero, wrap;

    assign tick       = sync_q[SYNC_STAGES-1] & ~prev_q;
    assign clear_zero = (state_q == StStop) && btn_clear;

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle: if (btn_start_stop) state_d = StRun;
            StRun: begin
                if (btn_start_stop) state_d = StStop;
`ifdef SW_LAP_EN
                else if (btn_lap) state_d = StLap;
`endif
            end
            StStop: begin
                if (btn_clear) state_d = StIdle;
                else if (btn_start_stop) state_d = StRun;
            end
`ifdef SW_LAP_EN
            StLap: begin
                if (btn_start_stop) state_d = StStop;
                else if (btn_lap) state_d = StRun;
            end
`endif
            default: state_d = StIdle;
        endcase
    end

    // Counting is gated on the pre-edge state, so a tick on the stop edge still lands.
    always_comb begin
        counting = (state_q == StRun);
`ifdef SW_LAP_EN
        counting = counting || (state_q == StLap);
`endif
        running_d = (state_d == StRun);
`ifdef SW_LAP_EN
        running_d = running_d || (state_d == StLap);
`endif
    end

    always_comb begin
        cnt_d = cnt_q;
        wrap  = 1'b0;
        if (clear_zero) begin
            cnt_d = '0;
        end else if (tick && counting) begin
            if (cnt_q[0] != 4'd9) cnt_d[0] = cnt_q[0] + 4'd1;
            else begin
                cnt_d[0] = 4'd0;
                if (cnt_q[1] != 4'd9) cnt_d[1] = cnt_q[1] + 4'd1;
                else begin
                    cnt_d[1] = 4'd0;
                    if (cnt_q[2] != 4'd9) cnt_d[2] = cnt_q[2] + 4'd1;
                    else begin
                        cnt_d[2] = 4'd0;
                        if (cnt_q[3] != 4'd5) cnt_d[3] = cnt_q[3] + 4'd1;
                        else begin
                            cnt_d[3] = 4'd0;
                            if (cnt_q[5] == MinTMax && cnt_q[4] == MinUMax) begin
                                cnt_d[5] = 4'd0;
                                cnt_d[4] = 4'd0;
                                wrap     = 1'b1;
                            end else if (cnt_q[4] != 4'd9) begin
                                cnt_d[4] = cnt_q[4] + 4'd1;
                            end else begin
                                cnt_d[4] = 4'd0;
                                cnt_d[5] = cnt_q[5] + 4'd1;
                            end
                        end
                    end
                end
            end
        end
    end

    always_comb begin
        digits_d = cnt_d;
`ifdef SW_LAP_EN
        // Entering or staying in LAP holds whatever was on display before this edge.
        if (state_d == StLap) digits_d = digits_q;
`endif
    end

    always_ff @(posedge clk_in) begin
        if (res) begin
            state_q    <= StIdle;
            sync_q     <= '0;
            prev_q     <= 1'b0;
            cnt_q      <= '0;
            digits_q   <= '0;
            running_q  <= 1'b0;
            overflow_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            sync_q     <= {sync_q[SYNC_STAGES-2:0], clk_100};
            prev_q     <= sync_q[SYNC_STAGES-1];
            cnt_q      <= cnt_d;
            digits_q   <= digits_d;
            running_q  <= running_d;
            overflow_q <= wrap;
        end
    end

    assign digits   = digits_q;
    assign running  = running_q;
    assign overflow = overflow_q;

endmodule

// File: tb/tb_stopwatch_counter.sv
// Directed bench for stopwatch_counter; MINUTES_MAX=1 keeps the wrap test short.
`timescale 1ns/1ps
module tb_stopwatch_counter;

    logic        clk_in = 1'b0;
    logic        res;
    logic        clk_100;
    logic        btn_start_stop;
    logic        btn_clear;
    logic        btn_lap;
    logic [23:0] digits;
    logic        running;
    logic        overflow;

    int total = 0;
    int bad   = 0;
    int ovf_cycles;

    stopwatch_counter #(
        .MINUTES_MAX(1),
        .SYNC_STAGES(2)
    ) dut (
        .clk_in        (clk_in),
        .res           (res),
        .clk_100       (clk_100),
        .btn_start_stop(btn_start_stop),
        .btn_clear     (btn_clear),
        .btn_lap       (btn_lap),
        .digits        (digits),
        .running       (running),
        .overflow      (overflow)
    );

    always #5 clk_in = ~clk_in;

    task automatic check(input string tag, input logic [23:0] obs, input logic [23:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic ticks(input int n);
        repeat (n) begin
            clk_100 = 1'b1;
            @(negedge clk_in);
            clk_100 = 1'b0;
            @(negedge clk_in);
        end
    endtask

    task automatic settle();
        repeat (3) @(negedge clk_in);
    endtask

    task automatic press(input logic ss, input logic clr, input logic lap);
        btn_start_stop = ss;
        btn_clear      = clr;
        btn_lap        = lap;
        @(negedge clk_in);
        btn_start_stop = 1'b0;
        btn_clear      = 1'b0;
        btn_lap        = 1'b0;
    endtask

    // Tick reaches the counter two edges after clk_100 is first sampled high.
    task automatic button_on_tick(input logic ss);
        clk_100 = 1'b1;
        @(negedge clk_in);
        clk_100 = 1'b0;
        @(negedge clk_in);
        press(ss, 1'b0, 1'b0);
    endtask

    initial begin
        res = 1'b1; clk_100 = 1'b0;
        btn_start_stop = 1'b0; btn_clear = 1'b0; btn_lap = 1'b0;

        // Reset with clk_100 toggling
        repeat (3) begin
            @(negedge clk_in);
            clk_100 = ~clk_100;
        end
        @(negedge clk_in);
        check("rst_digits", digits, 24'h000000);
        check("rst_running", 24'(running), 24'h0);
        check("rst_overflow", 24'(overflow), 24'h0);
        res = 1'b0; clk_100 = 1'b0;
        ticks(2);
        settle();
        check("idle_no_count", digits, 24'h000000);

        // Basic run / stop / clear
        press(1'b1, 1'b0, 1'b0);
        check("start_running", 24'(running), 24'h1);
        ticks(150);
        settle();
        check("run_150", digits, 24'h000150);
        press(1'b1, 1'b0, 1'b0);
        ticks(10);
        settle();
        check("stop_hold", digits, 24'h000150);
        check("stop_running", 24'(running), 24'h0);
        press(1'b1, 1'b0, 1'b0);
        press(1'b0, 1'b1, 1'b0);
        check("clear_ign_run_digits", digits, 24'h000150);
        check("clear_ign_run_running", 24'(running), 24'h1);
        press(1'b1, 1'b0, 1'b0);
        press(1'b0, 1'b1, 1'b0);
        check("clear_stop_digits", digits, 24'h000000);
        check("clear_stop_running", 24'(running), 24'h0);

        // Carries and wrap at 01:59.99
        press(1'b1, 1'b0, 1'b0);
        ticks(6000);
        settle();
        check("carry_to_min", digits, 24'h010000);
        ticks(5999);
        settle();
        check("preload_max", digits, 24'h015999);
        check("no_ovf_yet", 24'(overflow), 24'h0);
        ovf_cycles = 0;
        clk_100 = 1'b1;
        @(negedge clk_in);
        clk_100 = 1'b0;
        repeat (6) begin
            @(negedge clk_in);
            if (overflow) ovf_cycles++;
        end
        check("ovf_one_cycle", 24'(ovf_cycles), 24'd1);
        check("wrap_digits", digits, 24'h000000);
        check("wrap_running", 24'(running), 24'h1);

        // Simultaneous buttons
        press(1'b1, 1'b0, 1'b0);
        press(1'b1, 1'b1, 1'b0);
        check("clr_ss_digits", digits, 24'h000000);
        check("clr_ss_running", 24'(running), 24'h0);
        press(1'b1, 1'b0, 1'b0);
        ticks(3);
        settle();
        check("rerun_3", digits, 24'h000003);
        press(1'b1, 1'b0, 1'b1);
        check("ss_lap_stop", 24'(running), 24'h0);
        press(1'b0, 1'b1, 1'b0);
        check("clear_after_ss_lap", digits, 24'h000000);

        // Start / stop on the tick cycle
        button_on_tick(1'b1);
        settle();
        check("start_on_tick", digits, 24'h000000);
        check("start_on_tick_run", 24'(running), 24'h1);
        ticks(5);
        settle();
        check("run_5", digits, 24'h000005);
        button_on_tick(1'b1);
        settle();
        check("stop_on_tick", digits, 24'h000006);
        ticks(2);
        settle();
        check("stop_on_tick_hold", digits, 24'h000006);
        press(1'b0, 1'b1, 1'b0);

        // Lap freeze (or live display without the feature)
        press(1'b1, 1'b0, 1'b0);
        ticks(200);
        settle();
        check("lap_pre", digits, 24'h000200);
        press(1'b0, 1'b0, 1'b1);
        ticks(300);
        settle();
`ifdef SW_LAP_EN
        check("lap_frozen", digits, 24'h000200);
`else
        check("lap_live", digits, 24'h000500);
`endif
        check("lap_running", 24'(running), 24'h1);
        press(1'b0, 1'b0, 1'b1);
        check("lap_release", digits, 24'h000500);
        ticks(1);
        settle();
        check("lap_release_live", digits, 24'h000501);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
